regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback sources: the execute-stage result (ex) and the memory-stage load result (mem). Each source has a one-entry holding buffer and a valid/ready handshake. An age-ordered grant drives the register file's write-enable, write-address and write-data inputs. The block also reports read-after-write hazards for the two register file read addresses, and keeps a saturating count of write-port conflicts.

Parameters:
DATA_WIDTH, 32, width of write data and buffers
CNT_WIDTH, 16, width of the conflict counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
ex_valid  input  1  ex source presents a write
ex_ready  output  1  ex buffer can accept this cycle
ex_addr  input  5  ex destination register
ex_data  input  DATA_WIDTH  ex write data
mem_valid  input  1  mem source presents a write
mem_ready  output  1  mem buffer can accept this cycle
mem_addr  input  5  mem destination register
mem_data  input  DATA_WIDTH  mem write data
rf_we  output  1  to register file write enable
rf_waddr  output  5  to register file write address
rf_wdata  output  DATA_WIDTH  to register file write data
rd_addr1  input  5  register file read address 1
rd_addr2  input  5  register file read address 2
hazard1  output  1  rd_addr1 has a pending, uncommitted write
hazard2  output  1  rd_addr2 has a pending, uncommitted write
conflict_cnt  output  CNT_WIDTH  cycles in which both buffers were valid (saturating)

Behaviour:
- Each source has a buffer: valid bit, 5-bit addr, DATA_WIDTH data. One age bit, mem_older, orders the two buffers.
- Accept: a buffer fills on the edge where src_valid && src_ready. src_ready = !buf_valid || (buffer granted this cycle), so each source sustains one write per cycle when uncontested.
- Grant, combinational from buffer state:
  - Only one buffer valid: that buffer is granted.
  - Both valid: the older buffer is granted. If both filled on the same edge, mem is older.
  - Age rule: a buffer that filled on an earlier edge is older.
- Writes to x0:
  - Accepted and granted normally (they consume a slot).
  - rf_we = 0 during that cycle; rf_waddr and rf_wdata are still driven.
  - They never raise a hazard.
- rf_we = granted buffer valid && addr != 0. rf_waddr and rf_wdata come from the granted buffer. When nothing is granted, rf_waddr = 0 and rf_wdata = 0.
- The granted buffer is released on the following rising edge. It refills on that same edge if its source handshakes.
- Latency: a write accepted at edge N drives rf_we during cycle N+1 if uncontested, and during N+2 if it loses one arbitration. The worst case is 2 cycles, because age ordering prevents starvation.
- hazardK = (rd_addrK != 0) && ((ex_buf_valid && ex_addr_q == rd_addrK) || (mem_buf_valid && mem_addr_q == rd_addrK)). Combinational, same cycle.
- Same-address writes from both buffers commit in age order; the younger value is the one left in the register.
- conflict_cnt increments on each rising edge where both buffers were valid. It saturates at all-ones.
- Reset: all buffers invalid, mem_older = 0, conflict_cnt = 0. During reset, rf_we = 0, ex_ready = mem_ready = 1, hazard1 = hazard2 = 0. Writes pending at reset are discarded.
- src_valid while src_ready = 0: the source must hold addr and data stable. The block samples nothing.

Decomposition:
- Shared package: REG_ADDR_W = 5, REG_ZERO = 5'd0, and the source index encodings SRC_EX = 0 and SRC_MEM = 1.
- One natural sub-module, wb_hold_buf: valid/addr/data buffer with fill and release. It is instantiated twice, and the arbiter and age bit wrap it.

Test Plan:
1. Reset, then ex writes x5 = 0x0000_00AA -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xAA; ex_ready stays 1; conflict_cnt = 0.
2. Same edge: ex x3 = 0x11 and mem x4 = 0x22 -> cycle 1 grants mem (x4 = 0x22), cycle 2 grants ex (x3 = 0x11); conflict_cnt = 1; ex_ready = 0 in cycle 1.
3. Same edge: mem x7 = 0x1, ex x7 = 0x2 -> commit order 0x1 then 0x2. hazard1 with rd_addr1 = 7 is high for both cycles, then low.
4. ex writes x0 = 0xFFFF -> slot consumed for one cycle; rf_we stays 0; hazard1 with rd_addr1 = 0 is 0.
5. Both sources valid every cycle for 10 cycles -> writes alternate by age; no source is granted twice in a row while the other waits; conflict_cnt rises monotonically.
6. rst asserted while both buffers are full -> next cycle rf_we = 0, both ready = 1, hazards = 0, conflict_cnt = 0; the discarded writes never appear on rf_we.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SRC_EX  = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // A pending write to x0 never blocks a reader.
  function automatic logic addr_hit(input logic                  buf_valid,
                                    input logic [REG_ADDR_W-1:0] buf_addr,
                                    input logic [REG_ADDR_W-1:0] rd_addr);
    return buf_valid && (buf_addr == rd_addr) && (rd_addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_hold_buf.sv
// One-entry writeback holding buffer: fill loads addr/data, drain frees the slot.
module wb_hold_buf
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill,
  input  logic                  drain,
  input  logic [REG_ADDR_W-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  valid,
  output logic [REG_ADDR_W-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Fill wins over drain so a granted slot can be refilled on its release edge.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (drain) valid_d = 1'b0;
    if (fill) begin
      valid_d = 1'b1;
      addr_d  = in_addr;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Age-ordered arbitration of the ex and mem writeback sources onto the single
// register-file write port, with RAW hazard flags and a conflict counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  logic                  ex_buf_valid, mem_buf_valid;
  logic [REG_ADDR_W-1:0] ex_addr_q, mem_addr_q;
  logic [DATA_WIDTH-1:0] ex_data_q, mem_data_q;

  logic                  mem_older_q, mem_older_d;
  logic [CNT_WIDTH-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic ex_gnt, mem_gnt, gnt_any;
  logic ex_fill, mem_fill;
  src_e gnt_src;

  wb_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_ex_buf (
    .clk     (clk),
    .rst     (rst),
    .fill    (ex_fill),
    .drain   (ex_gnt),
    .in_addr (ex_addr),
    .in_data (ex_data),
    .valid   (ex_buf_valid),
    .addr    (ex_addr_q),
    .data    (ex_data_q)
  );

  wb_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_mem_buf (
    .clk     (clk),
    .rst     (rst),
    .fill    (mem_fill),
    .drain   (mem_gnt),
    .in_addr (mem_addr),
    .in_data (mem_data),
    .valid   (mem_buf_valid),
    .addr    (mem_addr_q),
    .data    (mem_data_q)
  );

  always_comb begin
    mem_gnt   = mem_buf_valid && (!ex_buf_valid || mem_older_q);
    ex_gnt    = ex_buf_valid && !mem_gnt;
    gnt_any   = !rst && (ex_gnt || mem_gnt);
    gnt_src   = mem_gnt ? SRC_MEM : SRC_EX;

    ex_ready  = rst || !ex_buf_valid || ex_gnt;
    mem_ready = rst || !mem_buf_valid || mem_gnt;
    ex_fill   = ex_valid && ex_ready;
    mem_fill  = mem_valid && mem_ready;

    rf_waddr = '0;
    rf_wdata = '0;
    if (gnt_any) begin
      if (gnt_src == SRC_MEM) begin
        rf_waddr = mem_addr_q;
        rf_wdata = mem_data_q;
      end else begin
        rf_waddr = ex_addr_q;
        rf_wdata = ex_data_q;
      end
    end
    rf_we = gnt_any && (rf_waddr != REG_ZERO);

    hazard1 = !rst && (addr_hit(ex_buf_valid, ex_addr_q, rd_addr1) ||
                       addr_hit(mem_buf_valid, mem_addr_q, rd_addr1));
    hazard2 = !rst && (addr_hit(ex_buf_valid, ex_addr_q, rd_addr2) ||
                       addr_hit(mem_buf_valid, mem_addr_q, rd_addr2));

    // A buffer that survives the edge is older than anything filling beside it;
    // when both fill together mem takes precedence.
    mem_older_d = mem_older_q;
    if (mem_buf_valid && !mem_gnt)  mem_older_d = 1'b1;
    else if (ex_buf_valid && !ex_gnt) mem_older_d = 1'b0;
    else if (ex_fill && mem_fill)   mem_older_d = 1'b1;

    conflict_cnt_d = conflict_cnt_q;
    if (ex_buf_valid && mem_buf_valid && (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_older_q    <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      mem_older_q    <= mem_older_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule
